prv_prot_check_arbiter: RTL and testbench

Time-shares one memory-protection checker (PMA/PMP lookup unit) between the fetch port (iren/iaddr/i_acc_width) and the data port (dren/dwen/daddr/d_acc_width) of the privilege block. A small FSM selects the winning requester, issues the checker transaction with a valid/ready handshake, waits for the variable-latency response, and returns a one-cycle acknowledge with fault flags. These flags drive prot_fault_i, prot_fault_l and prot_fault_s. A pipe_clear flush aborts outstanding work without producing a stale acknowledge.

---
 rtl/pma_types_1_12_pkg.sv | 13 +
 rtl/prv_prot_types_pkg.sv | 29 ++
 rtl/prv_prot_check_arbiter_if.sv | 27 ++
 rtl/prv_prot_check_arbiter_starve_ctr.sv | 37 +++
 rtl/prv_prot_check_arbiter.sv | 135 +++++++++++++
 tb/tb_prv_prot_check_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/pma_types_1_12_pkg.sv
// Shared PMA type definitions used by the protection checker path.
package pma_types_1_12_pkg;

  localparam int unsigned RAM_ADDR_SIZE = 32;

  typedef enum logic [1:0] {
    ACC_BYTE  = 2'd0,
    ACC_HALF  = 2'd1,
    ACC_WORD  = 2'd2,
    ACC_DWORD = 2'd3
  } pma_accwidth_t;

endpackage

// File: rtl/prv_prot_types_pkg.sv
// Types shared by the privilege-block protection-check arbiter.
package prv_prot_types_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } prot_kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Data-port check kind from the store/load select.
  function automatic prot_kind_t data_kind(input logic is_write);
    return is_write ? STORE : LOAD;
  endfunction

endpackage

// File: rtl/prv_prot_check_arbiter_if.sv
// Request/response channel between the arbiter and the PMA/PMP checker.
interface prv_prot_check_arbiter_if
  import pma_types_1_12_pkg::*;
  import prv_prot_types_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_SIZE
);

  logic              chk_valid;
  logic              chk_ready;
  logic [ADDR_W-1:0] chk_addr;
  pma_accwidth_t     chk_acc_width;
  prot_kind_t        chk_kind;
  logic              chk_rsp_valid;
  logic              chk_rsp_fault;

  modport master (
    output chk_valid, chk_addr, chk_acc_width, chk_kind,
    input  chk_ready, chk_rsp_valid, chk_rsp_fault
  );

  modport slave (
    input  chk_valid, chk_addr, chk_acc_width, chk_kind,
    output chk_ready, chk_rsp_valid, chk_rsp_fault
  );

endinterface

// File: rtl/prv_prot_check_arbiter_starve_ctr.sv
// Saturating count of data grants that bypassed a pending fetch.
module prv_prot_starve_ctr
  import prv_prot_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic grant,
  input  logic grant_data,
  input  logic fetch_pend,
  output logic fetch_prio_c
);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // Bump on a data grant that skipped a waiting fetch, otherwise clear on any grant.
  always_comb begin
    cnt_d = cnt_q;
    if (grant) begin
      if (grant_data && fetch_pend) begin
        if (cnt_q != STARVE_W'(STARVE_MAX)) cnt_d = cnt_q + STARVE_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fetch_prio_c = (cnt_q == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/prv_prot_check_arbiter.sv
// Shares one protection checker between the fetch and data ports.
module prv_prot_check_arbiter
  import pma_types_1_12_pkg::*;
  import prv_prot_types_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAM_ADDR_SIZE,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      i_req,
  input  logic [ADDR_W-1:0]         i_addr,
  input  pma_accwidth_t             i_acc_width,
  output logic                      i_ack,
  output logic                      i_fault,
  input  logic                      d_req,
  input  logic                      d_write,
  input  logic [ADDR_W-1:0]         d_addr,
  input  pma_accwidth_t             d_acc_width,
  output logic                      d_ack,
  output logic                      d_fault_l,
  output logic                      d_fault_s,
  prv_prot_check_arbiter_if.master  chk
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              chk_valid_q, chk_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  pma_accwidth_t     width_q, width_d;
  prot_kind_t        kind_q, kind_d;

  logic fetch_prio_c;
  logic grant;
  logic grant_data;
  logic rsp_done;

  // Arbitration only happens from IDLE, and never in a flush cycle.
  assign grant      = (state_q == IDLE) && !flush && (i_req || d_req);
  assign grant_data = d_req && !(i_req && fetch_prio_c);

  prv_prot_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK          (CLK),
    .RST          (RST),
    .grant        (grant),
    .grant_data   (grant_data),
    .fetch_pend   (i_req),
    .fetch_prio_c (fetch_prio_c)
  );

  // Next-state and captured-request logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    chk_valid_d = chk_valid_q;
    addr_d      = addr_q;
    width_d     = width_q;
    kind_d      = kind_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = ISSUE;
          chk_valid_d = 1'b1;
          if (grant_data) begin
            owner_d = OWN_DATA;
            addr_d  = d_addr;
            width_d = d_acc_width;
            kind_d  = data_kind(d_write);
          end else begin
            owner_d = OWN_FETCH;
            addr_d  = i_addr;
            width_d = i_acc_width;
            kind_d  = FETCH;
          end
        end
      end
      ISSUE: begin
        if (chk_valid_q && chk.chk_ready) begin
          chk_valid_d = 1'b0;
          state_d     = flush ? DRAIN : WAIT;
        end else if (flush) begin
          chk_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      WAIT: begin
        if (chk.chk_rsp_valid) state_d = IDLE;
        else if (flush)        state_d = DRAIN;
      end
      DRAIN: begin
        if (chk.chk_rsp_valid) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        chk_valid_d = 1'b0;
      end
    endcase
  end

  // State and checker-request registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      chk_valid_q <= 1'b0;
      addr_q      <= '0;
      width_q     <= ACC_BYTE;
      kind_q      <= FETCH;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      chk_valid_q <= chk_valid_d;
      addr_q      <= addr_d;
      width_q     <= width_d;
      kind_q      <= kind_d;
    end
  end

  // Response is forwarded straight to the owner; a concurrent flush suppresses it.
  assign rsp_done  = (state_q == WAIT) && chk.chk_rsp_valid && !flush;
  assign i_ack     = rsp_done && (owner_q == OWN_FETCH);
  assign d_ack     = rsp_done && (owner_q == OWN_DATA);
  assign i_fault   = i_ack && chk.chk_rsp_fault;
  assign d_fault_l = d_ack && chk.chk_rsp_fault && (kind_q == LOAD);
  assign d_fault_s = d_ack && chk.chk_rsp_fault && (kind_q == STORE);

  assign chk.chk_valid     = chk_valid_q;
  assign chk.chk_addr      = addr_q;
  assign chk.chk_acc_width = width_q;
  assign chk.chk_kind      = kind_q;

endmodule

// File: tb/tb_prv_prot_check_arbiter.sv
// Randomized and directed bench for prv_prot_check_arbiter.
module tb_prv_prot_check_arbiter;
  import pma_types_1_12_pkg::*;
  import prv_prot_types_pkg::*;

  localparam int unsigned AW   = RAM_ADDR_SIZE;
  localparam int          SMAX = 2;

  logic          CLK, RST, flush;
  logic          i_req, d_req, d_write;
  logic [AW-1:0] i_addr, d_addr;
  pma_accwidth_t i_acc_width, d_acc_width;
  logic          i_ack, i_fault, d_ack, d_fault_l, d_fault_s;

  prv_prot_check_arbiter_if #(.ADDR_W(AW)) chk_if ();

  prv_prot_check_arbiter #(
    .ADDR_W     (AW),
    .STARVE_MAX (SMAX)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_acc_width (i_acc_width),
    .i_ack       (i_ack),
    .i_fault     (i_fault),
    .d_req       (d_req),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_acc_width (d_acc_width),
    .d_ack       (d_ack),
    .d_fault_l   (d_fault_l),
    .d_fault_s   (d_fault_s),
    .chk         (chk_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int starve_m = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Reference arbitration: data wins unless fetch has been bypassed SMAX times in a row.
  function automatic bit model_pick_fetch(input bit ip, input bit dp);
    bit f;
    f = ip && (!dp || starve_m == SMAX);
    if (f || !ip) starve_m = 0;
    else if (starve_m < SMAX) starve_m = starve_m + 1;
    return f;
  endfunction

  // Complete a transaction already sitting in ISSUE: accept now, respond next cycle.
  task automatic finish_txn(input string tag, input bit exp_fetch, input logic [AW-1:0] exp_addr, input bit f);
    chk_if.chk_ready = 1'b1;
    sample();
    chk_eq({tag, "_valid"}, chk_if.chk_valid, 1'b1);
    chk_eq({tag, "_addr"}, chk_if.chk_addr, exp_addr);
    chk_eq({tag, "_isfetch"}, chk_if.chk_kind == FETCH, exp_fetch);
    tick();
    chk_if.chk_ready     = 1'b0;
    chk_if.chk_rsp_valid = 1'b1;
    chk_if.chk_rsp_fault = f;
    sample();
    chk_eq({tag, "_iack"}, i_ack, exp_fetch);
    chk_eq({tag, "_dack"}, d_ack, !exp_fetch);
    chk_eq({tag, "_ifault"}, i_fault, exp_fetch && f);
    tick();
    chk_if.chk_rsp_valid = 1'b0;
    chk_if.chk_rsp_fault = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // Hold n_i fetch and n_d data checks pending; serve each with random backpressure/latency.
  task automatic run_batch(input int n_i_in, input int n_d_in);
    int n_i, n_d, cyc, rdly;
    bit seen, acc, win_f, f;
    logic [AW-1:0] exp_addr;
    prot_kind_t exp_kind;
    pma_accwidth_t exp_w;
    n_i = n_i_in;
    n_d = n_d_in;
    i_addr      = $urandom;
    i_acc_width = pma_accwidth_t'($urandom_range(0, 3));
    d_addr      = $urandom;
    d_acc_width = pma_accwidth_t'($urandom_range(0, 3));
    d_write     = 1'($urandom_range(0, 1));
    i_req       = (n_i > 0);
    d_req       = (n_d > 0);
    while (n_i > 0 || n_d > 0) begin
      cyc = 0; seen = 0; acc = 0;
      exp_addr = '0; exp_kind = FETCH; exp_w = ACC_BYTE; win_f = 0;
      while (!acc) begin
        chk_if.chk_ready = ($urandom_range(0, 3) != 0);
        sample();
        chk_eq("ack_before_rsp", {i_ack, d_ack}, 2'b00);
        if (chk_if.chk_valid) begin
          if (!seen) begin
            seen     = 1;
            win_f    = model_pick_fetch(n_i > 0, n_d > 0);
            exp_addr = win_f ? i_addr : d_addr;
            exp_w    = win_f ? i_acc_width : d_acc_width;
            exp_kind = win_f ? FETCH : (d_write ? STORE : LOAD);
          end
          chk_eq("chk_kind", chk_if.chk_kind, exp_kind);
          chk_eq("chk_addr", chk_if.chk_addr, exp_addr);
          chk_eq("chk_width", chk_if.chk_acc_width, exp_w);
          acc = chk_if.chk_ready;
        end
        tick();
        cyc++;
        if (!acc && cyc > 40) begin
          chk_eq("issue_timeout", 1'b0, 1'b1);
          i_req = 1'b0; d_req = 1'b0; chk_if.chk_ready = 1'b0;
          return;
        end
      end
      chk_if.chk_ready = 1'b0;
      rdly = $urandom_range(1, 5);
      f    = 1'($urandom_range(0, 1));
      for (int k = 1; k < rdly; k++) begin
        sample();
        chk_eq("ack_in_wait", {i_ack, d_ack}, 2'b00);
        chk_eq("valid_in_wait", chk_if.chk_valid, 1'b0);
        tick();
      end
      chk_if.chk_rsp_valid = 1'b1;
      chk_if.chk_rsp_fault = f;
      sample();
      chk_eq("i_ack", i_ack, win_f);
      chk_eq("d_ack", d_ack, !win_f);
      chk_eq("i_fault", i_fault, win_f && f);
      chk_eq("d_fault_l", d_fault_l, !win_f && f && exp_kind == LOAD);
      chk_eq("d_fault_s", d_fault_s, !win_f && f && exp_kind == STORE);
      tick();
      chk_if.chk_rsp_valid = 1'b0;
      chk_if.chk_rsp_fault = 1'b0;
      if (win_f) begin
        n_i--;
        i_req = (n_i > 0);
      end else begin
        n_d--;
        d_req       = (n_d > 0);
        d_addr      = $urandom;
        d_acc_width = pma_accwidth_t'($urandom_range(0, 3));
        d_write     = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ni, nd;
    RST = 1'b1; flush = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; i_acc_width = ACC_BYTE; d_acc_width = ACC_BYTE;
    chk_if.chk_ready = 1'b0; chk_if.chk_rsp_valid = 1'b0; chk_if.chk_rsp_fault = 1'b0;

    // Reset values.
    repeat (2) @(posedge CLK);
    sample();
    chk_eq("rst_valid", chk_if.chk_valid, 1'b0);
    chk_eq("rst_addr", chk_if.chk_addr, '0);
    chk_eq("rst_width", chk_if.chk_acc_width, 2'd0);
    chk_eq("rst_kind", chk_if.chk_kind, FETCH);
    chk_eq("rst_acks", {i_ack, d_ack, i_fault, d_fault_l, d_fault_s}, 5'b0);
    tick();
    RST = 1'b0;
    tick();

    // Minimum latency: ack two cycles after IDLE samples the request.
    i_addr = 32'h100; i_acc_width = ACC_WORD; i_req = 1'b1; chk_if.chk_ready = 1'b1;
    sample();
    chk_eq("lat_c0_valid", chk_if.chk_valid, 1'b0);
    tick();
    void'(model_pick_fetch(1'b1, 1'b0));
    finish_txn("lat", 1'b1, 32'h100, 1'b0);
    sample();
    chk_eq("lat_ack_pulse", i_ack, 1'b0);

    // Stray response in IDLE is ignored.
    chk_if.chk_rsp_valid = 1'b1; chk_if.chk_rsp_fault = 1'b1;
    sample();
    chk_eq("idle_rsp_acks", {i_ack, d_ack, i_fault}, 3'b0);
    tick();
    chk_if.chk_rsp_valid = 1'b0; chk_if.chk_rsp_fault = 1'b0;
    sample();
    chk_eq("idle_rsp_valid", chk_if.chk_valid, 1'b0);
    tick();

    // Starvation order DATA, DATA, FETCH, DATA, then random batches.
    run_batch(1, 3);
    for (int b = 0; b < 60; b++) begin
      ni = $urandom_range(0, 1);
      nd = $urandom_range(0, 3);
      if (ni == 0 && nd == 0) nd = 1;
      run_batch(ni, nd);
    end
    tick();

    // Flush in WAIT, response 3 cycles later, new d_req raised during DRAIN.
    d_addr = 32'h2000; d_write = 1'b0; d_acc_width = ACC_HALF; d_req = 1'b1; chk_if.chk_ready = 1'b1;
    void'(model_pick_fetch(1'b0, 1'b1));
    tick();
    sample();
    chk_eq("fw_issue_valid", chk_if.chk_valid, 1'b1);
    tick();
    d_req = 1'b0; flush = 1'b1;
    sample();
    chk_eq("fw_flush_ack", d_ack, 1'b0);
    tick();
    flush = 1'b0; d_addr = 32'h3000; d_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk_eq("fw_drain_valid", chk_if.chk_valid, 1'b0);
      tick();
    end
    chk_if.chk_rsp_valid = 1'b1; chk_if.chk_rsp_fault = 1'b1;
    sample();
    chk_eq("fw_drain_acks", {i_ack, d_ack, d_fault_l}, 3'b0);
    tick();
    chk_if.chk_rsp_valid = 1'b0; chk_if.chk_rsp_fault = 1'b0;
    sample();
    chk_eq("fw_idle_valid", chk_if.chk_valid, 1'b0);
    tick();
    void'(model_pick_fetch(1'b0, 1'b1));
    finish_txn("fw_regrant", 1'b0, 32'h3000, 1'b0);
    tick();

    // Flush in ISSUE without handshake returns to IDLE.
    i_addr = 32'h440; i_req = 1'b1; chk_if.chk_ready = 1'b0;
    void'(model_pick_fetch(1'b1, 1'b0));
    tick();
    flush = 1'b1; i_req = 1'b0;
    sample();
    chk_eq("fi_issue_valid", chk_if.chk_valid, 1'b1);
    tick();
    flush = 1'b0;
    sample();
    chk_eq("fi_after_valid", chk_if.chk_valid, 1'b0);
    chk_eq("fi_after_ack", i_ack, 1'b0);
    tick();

    // Flush in ISSUE with handshake goes to DRAIN; request held off until response.
    i_addr = 32'h880; i_req = 1'b1; chk_if.chk_ready = 1'b1;
    void'(model_pick_fetch(1'b1, 1'b0));
    tick();
    flush = 1'b1; i_req = 1'b0;
    sample();
    chk_eq("fh_issue_valid", chk_if.chk_valid, 1'b1);
    tick();
    flush = 1'b0; chk_if.chk_ready = 1'b0; i_addr = 32'h990; i_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk_eq("fh_drain_valid", chk_if.chk_valid, 1'b0);
      tick();
    end
    chk_if.chk_rsp_valid = 1'b1;
    sample();
    chk_eq("fh_drain_ack", i_ack, 1'b0);
    tick();
    chk_if.chk_rsp_valid = 1'b0;
    sample();
    chk_eq("fh_idle_valid", chk_if.chk_valid, 1'b0);
    tick();
    void'(model_pick_fetch(1'b1, 1'b0));
    finish_txn("fh_regrant", 1'b1, 32'h990, 1'b1);
    tick();

    // Flush in IDLE suppresses arbitration for that cycle.
    d_addr = 32'h5a0; d_write = 1'b1; d_req = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    sample();
    chk_eq("fidle_valid", chk_if.chk_valid, 1'b0);
    tick();
    void'(model_pick_fetch(1'b0, 1'b1));
    finish_txn("fidle", 1'b0, 32'h5a0, 1'b0);
    tick();

    // Reset mid-ISSUE clears outputs immediately; a new fetch then completes.
    i_addr = 32'h700; i_req = 1'b1; chk_if.chk_ready = 1'b0;
    tick();
    sample();
    chk_eq("rmid_valid_pre", chk_if.chk_valid, 1'b1);
    #1 RST = 1'b1;
    #1;
    chk_eq("rmid_valid", chk_if.chk_valid, 1'b0);
    chk_eq("rmid_addr", chk_if.chk_addr, '0);
    chk_eq("rmid_acks", {i_ack, d_ack}, 2'b0);
    tick();
    RST = 1'b0;
    starve_m = 0;
    i_addr = 32'h704;
    sample();
    chk_eq("rmid_idle_valid", chk_if.chk_valid, 1'b0);
    tick();
    void'(model_pick_fetch(1'b1, 1'b0));
    finish_txn("rmid_after", 1'b1, 32'h704, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
